// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the chunked adder: FSM state encoding and the
// chunk-count / counter-width helpers.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int nchunk_f(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int cnt_w_f(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for the chunked adder.
interface chunked_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );

endinterface

// File: rtl/chunked_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice; also exposes the carry
// into its top bit so the parent can derive signed overflow.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o,
    output logic             c_msb_o
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        s_o      = '0;
        carry[0] = cin_i;
        for (int i = 0; i < CHUNK; i++) begin
            s_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1] = (a_i[i] & b_i[i]) | ((a_i[i] ^ b_i[i]) & carry[i]);
        end
    end

    assign cout_o  = carry[CHUNK];
    assign c_msb_o = carry[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, carry held in a
// register between slices, result and flags presented behind valid/ready.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | in_ready high; accept operands on in_valid
//   RUN     | add chunk[count] with carry_q; last chunk sets flags
//   DONE    | out_valid high; hold results until out_ready
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            reset,
    chunked_adder_if.slave  bus
);

    localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
    localparam int CW     = cnt_w_f(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_e state_q, state_d;

    logic [NCHUNK-1:0][CHUNK-1:0] a_q, a_d;
    logic [NCHUNK-1:0][CHUNK-1:0] b_q, b_d;
    logic [NCHUNK-1:0][CHUNK-1:0] sum_q, sum_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         carry_q, carry_d;
    logic                         cout_q, cout_d;
    logic                         ovf_q, ovf_d;
    logic                         zero_q, zero_d;

    logic [CHUNK-1:0] ch_s;
    logic             ch_cout;
    logic             ch_cmsb;

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i     (a_q[count_q]),
        .b_i     (b_q[count_q]),
        .cin_i   (carry_q),
        .s_o     (ch_s),
        .cout_o  (ch_cout),
        .c_msb_o (ch_cmsb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is folded in as A + ~B + 1 at capture time.
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[count_q] = ch_s;
                carry_d        = ch_cout;
                count_d        = count_q + 1'b1;
                if (count_q == LAST) begin
                    cout_d  = ch_cout;
                    ovf_d   = ch_cmsb ^ ch_cout;
                    zero_d  = (sum_d == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench: directed vectors on the 16/4 build plus single-pass and
// other chunk sizes checked against an arithmetic reference model.
module tb_chunked_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   tests  = 0;
    int   fails  = 0;
    int   n_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns {cout, overflow, zero, sum}; cout for subtraction means "no borrow".
    function automatic logic [34:0] ref_model(input int w, input logic [31:0] a,
                                              input logic [31:0] b, input logic sub);
        logic [32:0] full;
        logic [31:0] mask, s, aa, bb;
        logic        co, ov, sa, sb, ss;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        aa = a & mask;
        bb = b & mask;
        if (sub) begin
            full = {1'b0, aa} - {1'b0, bb};
            co   = (aa >= bb);
        end else begin
            full = {1'b0, aa} + {1'b0, bb};
            co   = full[w];
        end
        s  = full[31:0] & mask;
        sa = aa[w-1];
        sb = bb[w-1];
        ss = s[w-1];
        ov = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        return {co, ov, (s == 32'h0), s};
    endfunction

    // ---------------- main 16/4 instance ----------------
    chunked_adder_if #(.WIDTH(16)) bus ();
    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .reset(rst), .bus(bus));

    exp_t q_main[$];
    logic seen_main = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid && !seen_main) begin
            if (q_main.size() == 0) begin
                check("spurious_out_valid", 32'(bus.out_valid), 32'h0);
            end else begin
                e = q_main.pop_front();
                check("sum",      32'(bus.sum),      e.sum);
                check("cout",     32'(bus.cout),     32'(e.cout));
                check("overflow", 32'(bus.overflow), 32'(e.ovf));
                check("zero",     32'(bus.zero),     32'(e.zero));
                check("latency",  32'(cyc - e.acc),  32'd4);
            end
        end
        seen_main = bus.out_valid;
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic push, input logic [15:0] es, input logic ec,
                        input logic eo, input logic ez);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'h1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        @(posedge clk);
        #1;
        if (push) begin
            e.sum = 32'(es); e.cout = ec; e.ovf = eo; e.zero = ez; e.acc = cyc;
            q_main.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_main.size() != 0 || bus.out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_main", 32'(q_main.size()), 32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'h1);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_sum",       32'(bus.sum),       32'h0);
        check("rst_flags",     32'({bus.cout, bus.overflow, bus.zero}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        send(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        drain();

        // Stall in DONE with in_valid asserted and operands wiggling.
        bus.out_ready = 1'b0;
        send(16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 20 && !bus.out_valid; n++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.sub      = 1'($urandom_range(0, 1));
            check("hold_in_ready",  32'(bus.in_ready),  32'h0);
            check("hold_out_valid", 32'(bus.out_valid), 32'h1);
            check("hold_sum",       32'(bus.sum),       32'h0007);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(bus.in_ready), 32'h1);
        send(16'h00FF, 16'h0F01, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        drain();

        // Abort on the second RUN cycle.
        send(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready",  32'(bus.in_ready),  32'h1);
        check("abort_out_valid", 32'(bus.out_valid), 32'h0);
        check("abort_sum",       32'(bus.sum),       32'h0);
        check("abort_flags",     32'({bus.cout, bus.overflow, bus.zero}), 32'h0);
        repeat (8) @(negedge clk);
        check("abort_no_valid",  32'(bus.out_valid), 32'h0);

        // Reset wins over a simultaneous in_valid.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 16'h0001;
        bus.b        = 16'h0001;
        bus.sub      = 1'b0;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_vs_valid_idle", 32'(bus.in_ready), 32'h1);

        send(16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0, 1'b0);
        drain();
        n_done++;
    end

    // ---------------- other chunk configurations ----------------
    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W      = (g == 0) ? 32 : 16;
        localparam int C      = (g == 0) ? 32 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
        localparam int NCH    = W / C;
        localparam logic [31:0] MASK = (W == 32) ? 32'hFFFF_FFFF : ((32'h1 << W) - 32'h1);

        logic grst;
        exp_t gq[$];
        logic seen = 1'b0;

        chunked_adder_if #(.WIDTH(W)) gif ();
        chunked_adder #(.WIDTH(W), .CHUNK(C)) u_dut (.clk(clk), .reset(grst), .bus(gif));

        always @(negedge clk) begin
            exp_t e;
            if (gif.out_valid && !seen) begin
                if (gq.size() == 0) begin
                    check("cfg_spurious_out_valid", 32'(gif.out_valid), 32'h0);
                end else begin
                    e = gq.pop_front();
                    check("cfg_sum",      32'(gif.sum),      e.sum);
                    check("cfg_cout",     32'(gif.cout),     32'(e.cout));
                    check("cfg_overflow", 32'(gif.overflow), 32'(e.ovf));
                    check("cfg_zero",     32'(gif.zero),     32'(e.zero));
                    check("cfg_latency",  32'(cyc - e.acc),  32'(NCH));
                end
            end
            seen = gif.out_valid;
        end

        initial begin
            logic [31:0] va, vb;
            logic        vs;
            logic [34:0] r;
            exp_t        e;
            int          n;
            grst          = 1'b1;
            gif.in_valid  = 1'b0;
            gif.a         = '0;
            gif.b         = '0;
            gif.sub       = 1'b0;
            gif.out_ready = 1'b1;
            repeat (3) @(negedge clk);
            grst = 1'b0;
            for (int k = 0; k <= 10; k++) begin
                if (k == 0) begin
                    va = 32'hFFFF_FFFF; vb = 32'h1; vs = 1'b0;
                end else begin
                    va = $urandom; vb = $urandom; vs = 1'($urandom_range(0, 1));
                    if (k == 3) begin vb = va; vs = 1'b1; end
                end
                va = va & MASK;
                vb = vb & MASK;
                n = 0;
                while (!gif.in_ready && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check("cfg_in_ready_wait", 32'(gif.in_ready), 32'h1);
                gif.in_valid = 1'b1;
                gif.a        = va[W-1:0];
                gif.b        = vb[W-1:0];
                gif.sub      = vs;
                @(posedge clk);
                #1;
                if (k == 0) begin
                    e.sum = 32'h0; e.cout = 1'b1; e.ovf = 1'b0; e.zero = 1'b1;
                end else begin
                    r = ref_model(W, va, vb, vs);
                    e.sum = r[31:0]; e.zero = r[32]; e.ovf = r[33]; e.cout = r[34];
                end
                e.acc = cyc;
                gq.push_back(e);
                @(negedge clk);
                gif.in_valid = 1'b0;
            end
            n = 0;
            while ((gq.size() != 0 || gif.out_valid) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("cfg_drain", 32'(gq.size()), 32'h0);
            n_done++;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            if (n_done == 5) break;
            @(posedge clk);
        end
        if (n_done != 5) check("global_timeout", 32'(n_done), 32'd5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
